// File: rtl/adc_sample_packer_64_pkg.sv
// Shared producer-side definitions for the ADC sample packer: FSM encodings,
// default pad word and the beats-per-sample helper.
package adc_sample_packer_64_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND  = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [63:0] FILL_WORD_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic int wps_of(input int nch);
        return (nch * 16) / 64;
    endfunction

endpackage

// File: rtl/adc_sample_packer_64_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
module adc_sample_packer_64_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/adc_sample_packer_64.sv
// Packs NCH x 16-bit ADC samples into 64-bit AXI4-Stream beats grouped into
// fixed-length packets; disabling DMA mid-packet pads out to the packet boundary.
module adc_sample_packer_64
    import adc_sample_packer_64_pkg::*;
#(
    parameter int          NCH       = 8,
    parameter int          PKT_WIDTH = 9,
    parameter logic [63:0] FILL_WORD = FILL_WORD_DEFAULT
) (
    input  logic              data_clk,
    input  logic              data_rst,
    input  logic              dma_ena,
    input  logic              new_sample,
    input  logic [NCH*16-1:0] adc_data,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              overrun,
    output logic [15:0]       overrun_cnt,
    output logic [31:0]       pkt_cnt,
    output logic [1:0]        state_o
);

    localparam int WPS    = wps_of(NCH);
    localparam int BIDX_W = (WPS > 1) ? $clog2(WPS) : 1;
    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(WPS - 1);

    state_t               state, state_nxt;
    logic [NCH*16-1:0]    sample_reg;
    logic                 busy, busy_nxt;
    logic [BIDX_W-1:0]    beat_idx;
    logic [PKT_WIDTH-1:0] pkt_beat, pkt_beat_nxt;

    logic xfer, final_xfer, accept, drop, arm;

    // All stream outputs derive from registers only; tready never reaches tvalid.
    assign m_axis_tvalid = (state == SEND && busy) || (state == FLUSH);
    assign m_axis_tlast  = m_axis_tvalid && (&pkt_beat);
    assign m_axis_tkeep  = 8'hFF;
    assign state_o       = state;

    always_comb begin
        m_axis_tdata = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata = busy ? sample_reg[64*int'(beat_idx) +: 64] : FILL_WORD;
        end
    end

    assign xfer       = m_axis_tvalid && m_axis_tready;
    assign final_xfer = xfer && busy && (beat_idx == LAST_BEAT);
    assign accept     = new_sample && dma_ena && (state == SEND) && (!busy || final_xfer);
    assign drop       = new_sample && dma_ena && (state == SEND) && busy && !final_xfer;
    assign arm        = (state == IDLE) && dma_ena;

    always_comb begin
        busy_nxt = busy;
        if (accept) begin
            busy_nxt = 1'b1;
        end else if (final_xfer) begin
            busy_nxt = 1'b0;
        end
        pkt_beat_nxt = pkt_beat;
        if (arm) begin
            pkt_beat_nxt = '0;
        end else if (xfer) begin
            pkt_beat_nxt = pkt_beat + 1'b1;
        end
    end

    // Disable decision looks at post-transfer occupancy so a packet that just
    // closed on this edge does not trigger a full pad packet.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dma_ena) state_nxt = SEND;
            SEND:    if (!dma_ena) state_nxt = (busy_nxt || pkt_beat_nxt != '0) ? FLUSH : IDLE;
            FLUSH:   if (xfer && m_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (data_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            beat_idx <= '0;
            pkt_beat <= '0;
            pkt_cnt  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            pkt_beat <= pkt_beat_nxt;
            if (accept || final_xfer) begin
                beat_idx <= '0;
            end else if (xfer && busy) begin
                beat_idx <= beat_idx + 1'b1;
            end
            if (xfer && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (arm) begin
                overrun <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge data_clk) begin
        if (accept) begin
            sample_reg <= adc_data;
        end
    end

    adc_sample_packer_64_sat_counter #(
        .W (16)
    ) u_overrun_cnt (
        .clk   (data_clk),
        .rst   (data_rst),
        .clr   (arm),
        .inc   (drop),
        .count (overrun_cnt)
    );

endmodule

// File: tb/tb_adc_sample_packer_64.sv
// Directed and randomized bench for adc_sample_packer_64 (NCH=8, PKT_WIDTH=3)
// against a queue-based reference model.
module tb_adc_sample_packer_64;

    localparam int          NCH   = 8;
    localparam int          PKT_W = 3;
    localparam int          PKT   = 1 << PKT_W;
    localparam int          WPS   = NCH * 16 / 64;
    localparam logic [63:0] FILL  = 64'hDEAD_BEEF_DEAD_BEEF;

    logic              clk;
    logic              rst;
    logic              ena;
    logic              ns;
    logic [NCH*16-1:0] adc;
    logic [63:0]       tdata;
    logic [7:0]        tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              ovr;
    logic [15:0]       ovr_cnt;
    logic [31:0]       pkts;
    logic [1:0]        st;

    adc_sample_packer_64 #(
        .NCH       (NCH),
        .PKT_WIDTH (PKT_W)
    ) dut (
        .data_clk      (clk),
        .data_rst      (rst),
        .dma_ena       (ena),
        .new_sample    (ns),
        .adc_data      (adc),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .overrun       (ovr),
        .overrun_cnt   (ovr_cnt),
        .pkt_cnt       (pkts),
        .state_o       (st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle / 1 send / 2 flush, pending beats of the
    // sample in flight, beat position within the current packet.
    int          m_mode = 0;
    logic [63:0] pend[$];
    int          m_pos  = 0;
    int          m_pkts = 0;
    int          m_ovr  = 0;
    int          m_ocnt = 0;

    logic [63:0] got_d[$];
    bit          got_l[$];
    logic [63:0] ref_d[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int s);
        logic [127:0] p;
        for (int k = 0; k < NCH; k++) p[16*k +: 16] = 16'(16'h0100 * s + k);
        return p;
    endfunction

    task automatic step();
        bit          ev, el, xf, acc, drp;
        logic [63:0] ed;
        @(negedge clk);
        ev = (m_mode == 1) ? (pend.size() > 0) : (m_mode == 2);
        ed = (pend.size() > 0) ? pend[0] : FILL;
        el = ev && (m_pos == PKT - 1);
        chk("tvalid", 64'(tvalid), 64'(ev));
        chk("tlast", 64'(tlast), 64'(el));
        if (ev) chk("tdata", tdata, ed);
        chk("state", 64'(st), 64'(m_mode));
        chk("overrun", 64'(ovr), 64'(m_ovr));
        chk("overrun_cnt", 64'(ovr_cnt), 64'(m_ocnt));
        chk("pkt_cnt", 64'(pkts), 64'(m_pkts));
        chk("tkeep", 64'(tkeep), 64'hFF);
        xf = ev && tready;
        if (xf) begin
            got_d.push_back(tdata);
            got_l.push_back(tlast);
        end
        if (rst) begin
            m_mode = 0; pend.delete(); m_pos = 0; m_pkts = 0; m_ovr = 0; m_ocnt = 0;
        end else begin
            acc = (m_mode == 1) && ns && ena && (pend.size() == 0 || (xf && pend.size() == 1));
            drp = (m_mode == 1) && ns && ena && !acc;
            if (xf) begin
                if (pend.size() > 0) void'(pend.pop_front());
                if (el) m_pkts++;
                m_pos = (m_pos + 1) % PKT;
            end
            if (acc) for (int j = 0; j < WPS; j++) pend.push_back(adc[64*j +: 64]);
            if (drp) begin
                m_ovr = 1;
                if (m_ocnt < 65535) m_ocnt++;
            end
            case (m_mode)
                0: if (ena) begin m_mode = 1; m_ovr = 0; m_ocnt = 0; m_pos = 0; end
                1: if (!ena) m_mode = (pend.size() > 0 || m_pos != 0) ? 2 : 0;
                default: if (xf && el) m_mode = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
    endtask

    task automatic chk_lasts(input string tag, input int n);
        chk({tag, "_beats"}, 64'(got_d.size()), 64'(n));
        for (int i = 0; i < got_l.size(); i++) chk({tag, "_last"}, 64'(got_l[i]), 64'(i == n - 1));
    endtask

    initial begin
        logic [127:0] smp;
        rst = 1'b1; ena = 1'b0; ns = 1'b0; adc = '0; tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("rst_tdata", tdata, 64'h0);
        chk("rst_tvalid", 64'(tvalid), 64'h0);
        chk("rst_pkt_cnt", 64'(pkts), 64'h0);
        rst = 1'b0;

        // Nominal stream, tready high, one sample every 4 cycles
        ena = 1'b1;
        step();
        clear_log();
        for (int s = 0; s < 4; s++) begin
            ns = 1'b1; adc = pat(s); step();
            ns = 1'b0; repeat (3) step();
        end
        repeat (3) step();
        chk_lasts("t1", 8);
        chk("t1_beat0", got_d[0], 64'h0003_0002_0001_0000);
        chk("t1_pkt_cnt", 64'(pkts), 64'd1);
        ref_d = got_d;

        // tready toggling every cycle, one sample every 6 cycles
        clear_log();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 6; c++) begin
                ns = (c == 0); adc = pat(s); tready = ~tready; step();
            end
        end
        ns = 1'b0;
        repeat (6) begin tready = ~tready; step(); end
        chk_lasts("t2", 8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) chk("t2_same_data", got_d[i], ref_d[i]);
        chk("t2_overrun", 64'(ovr), 64'h0);
        chk("t2_pkt_cnt", 64'(pkts), 64'd2);

        // Back-to-back samples landing on the final-beat cycle
        tready = 1'b1;
        clear_log();
        for (int s = 0; s < 3; s++) begin
            ns = 1'b1; adc = pat(10 + s); step();
            ns = 1'b0; step();
        end
        repeat (3) step();
        chk("t4_beats", 64'(got_d.size()), 64'd6);
        smp = pat(11);
        chk("t4_next_beat0", got_d[2], smp[63:0]);
        chk("t4_overrun_cnt", 64'(ovr_cnt), 64'h0);

        // Stalled sink: later samples are dropped
        tready = 1'b0;
        clear_log();
        for (int c = 0; c < 10; c++) begin
            ns = (c % 3 == 0) && (c < 9); adc = pat(30 + c); step();
        end
        ns = 1'b0;
        chk("t3_overrun", 64'(ovr), 64'h1);
        chk("t3_overrun_cnt", 64'(ovr_cnt), 64'd2);
        tready = 1'b1;
        repeat (4) step();
        chk("t3_beats", 64'(got_d.size()), 64'd2);
        smp = pat(30);
        chk("t3_beat0", got_d[0], smp[63:0]);
        chk("t3_pkt_cnt", 64'(pkts), 64'd3);

        // DMA disabled after three beats of a packet: pad flush
        clear_log();
        ns = 1'b1; adc = pat(20); step();
        ns = 1'b0; step();
        ns = 1'b1; adc = pat(21); step();
        ns = 1'b0; ena = 1'b0; step();
        repeat (8) step();
        chk_lasts("t5", 8);
        smp = pat(21);
        chk("t5_tail_beat", got_d[3], smp[127:64]);
        for (int i = 4; i < 8 && i < got_d.size(); i++) chk("t5_fill", got_d[i], FILL);
        chk("t5_state", 64'(st), 64'h0);
        chk("t5_pkt_cnt", 64'(pkts), 64'd4);

        // Reset mid-packet with a beat on the bus
        ena = 1'b1; step();
        ns = 1'b1; adc = pat(40); step();
        ns = 1'b0;
        chk("t6_pre_tvalid", 64'(tvalid), 64'h1);
        rst = 1'b1; step();
        chk("t6_tvalid", 64'(tvalid), 64'h0);
        chk("t6_state", 64'(st), 64'h0);
        chk("t6_pkt_cnt", 64'(pkts), 64'h0);
        chk("t6_overrun_cnt", 64'(ovr_cnt), 64'h0);
        rst = 1'b0;
        step();
        clear_log();
        for (int s = 0; s < 4; s++) begin
            ns = 1'b1; adc = pat(50 + s); step();
            ns = 1'b0; step();
        end
        repeat (3) step();
        chk_lasts("t6", 8);

        // Randomized traffic, sink backpressure and DMA enable changes
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) ena = ~ena;
            ns     = ($urandom_range(0, 2) == 0);
            adc    = {$urandom, $urandom, $urandom, $urandom};
            tready = ($urandom_range(0, 3) != 0);
            step();
        end
        ena = 1'b0; ns = 1'b0; tready = 1'b1;
        repeat (20) step();
        chk("end_state", 64'(st), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
